// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
// countdown_timer: HH:MM:SS countdown clocked by a 1 Hz clock.
// States IDLE, RUN, PAUSE and ALARM. Input priority on each edge is load > stop > start.
// A load with any field out of range is rejected: load_err pulses and nothing else changes.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for auto-reload. On expiry the preset
// is reloaded, the timer keeps running and alarm pulses for one cycle. ALARM_HOLD is unused
// in that build.
module countdown_timer #(
   parameter int ALARM_HOLD = 5
) (
   input  logic       Clk_1sec,
   input  logic       reset,
   input  logic       load,
   input  logic [4:0] load_hours,
   input  logic [5:0] load_minutes,
   input  logic [5:0] load_seconds,
   input  logic       start,
   input  logic       stop,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       alarm,
   output logic       load_err
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

   localparam logic [5:0] HOLD_LAST = 6'(ALARM_HOLD - 1);

   state_t     state, state_next;
   logic [5:0] hold_cnt;

   logic       load_legal, load_ok, load_bad;
   logic       time_zero, time_one;
   logic       start_ok, run_tick, expiry, hold_done;
   logic [4:0] dec_hours;
   logic [5:0] dec_minutes, dec_seconds;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [4:0] reload_hours;
   logic [5:0] reload_minutes, reload_seconds;
   logic       reload_zero, reload_pulse;
`endif

   // Qualify the inputs against the current state and time.
   // Any load, accepted or rejected, blocks stop, start and the decrement on that edge.
   always_comb begin
      load_legal = (load_hours <= 5'd23) && (load_minutes <= 6'd59) && (load_seconds <= 6'd59);
      load_ok    = load && load_legal;
      load_bad   = load && !load_legal;
      time_zero  = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd0);
      time_one   = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd1);
      start_ok   = !load && !stop && start && ((state == IDLE) || (state == PAUSE)) && !time_zero;
      run_tick   = !load && !stop && (state == RUN);
      // time_zero is included so RUN can never sit at zero and underflow.
      expiry     = run_tick && (time_one || time_zero);
      hold_done  = (hold_cnt >= HOLD_LAST);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_zero = (reload_hours == 5'd0) && (reload_minutes == 6'd0) && (reload_seconds == 6'd0);
`endif
   end

   // One-second decrement with borrow; holds at 00:00:00.
   always_comb begin
      dec_hours   = hours;
      dec_minutes = minutes;
      dec_seconds = seconds;
      if (seconds != 6'd0) begin
         dec_seconds = seconds - 6'd1;
      end else if (minutes != 6'd0) begin
         dec_minutes = minutes - 6'd1;
         dec_seconds = 6'd59;
      end else if (hours != 5'd0) begin
         dec_hours   = hours - 5'd1;
         dec_minutes = 6'd59;
         dec_seconds = 6'd59;
      end
   end

   // State register.
   always_ff @(posedge Clk_1sec or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: a valid load forces IDLE from any state, otherwise per-state transitions.
   always_comb begin
      state_next = state;
      if (load_ok) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, PAUSE: if (start_ok) state_next = RUN;
            RUN: begin
               if (!load && stop) begin
                  state_next = PAUSE;
               end else if (expiry) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  state_next = reload_zero ? IDLE : RUN;
`else
                  state_next = ALARM;
`endif
               end
            end
            ALARM: if (!load && (stop || hold_done)) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Time, preset, alarm hold counter and load_err pulse.
   always_ff @(posedge Clk_1sec or posedge reset) begin
      if (reset) begin
         hours          <= 5'd0;
         minutes        <= 6'd0;
         seconds        <= 6'd0;
         hold_cnt       <= 6'd0;
         load_err       <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_hours   <= 5'd0;
         reload_minutes <= 6'd0;
         reload_seconds <= 6'd0;
         reload_pulse   <= 1'b0;
`endif
      end else begin
         load_err <= load_bad;
         if (load_ok) begin
            hours          <= load_hours;
            minutes        <= load_minutes;
            seconds        <= load_seconds;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_hours   <= load_hours;
            reload_minutes <= load_minutes;
            reload_seconds <= load_seconds;
`endif
         end else if (run_tick) begin
            if (expiry) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               hours   <= reload_hours;
               minutes <= reload_minutes;
               seconds <= reload_seconds;
`else
               hours   <= 5'd0;
               minutes <= 6'd0;
               seconds <= 6'd0;
`endif
            end else begin
               hours   <= dec_hours;
               minutes <= dec_minutes;
               seconds <= dec_seconds;
            end
         end else if ((state == ALARM) && (state_next == IDLE)) begin
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
         end
         // The counter restarts at zero on every entry to ALARM and freezes on a rejected load.
         if (state_next != ALARM)         hold_cnt <= 6'd0;
         else if ((state == ALARM) && !load) hold_cnt <= hold_cnt + 6'd1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_pulse <= expiry && !reload_zero;
`endif
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      running = (state == RUN);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      alarm   = (state == ALARM) || reload_pulse;
`else
      alarm   = (state == ALARM);
`endif
   end

endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
// Scoreboard bench for countdown_timer: each row drives one edge of stimulus and queues the
// outputs expected after that edge; the entry is popped and compared 1 ns after the edge.
module tb_countdown_timer;

   logic       Clk_1sec = 1'b0;
   logic       reset, load, start, stop;
   logic [4:0] load_hours;
   logic [5:0] load_minutes, load_seconds;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic       running, alarm, load_err;

   countdown_timer #(.ALARM_HOLD(5)) dut (
      .Clk_1sec(Clk_1sec), .reset(reset), .load(load),
      .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
      .start(start), .stop(stop),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .running(running), .alarm(alarm), .load_err(load_err)
   );

   always #5 Clk_1sec = ~Clk_1sec;

   typedef struct packed {
      logic [4:0] h; logic [5:0] m; logic [5:0] s; logic run; logic alm; logic err;
   } obs_t;

   typedef struct packed {
      logic ld; logic [4:0] lh; logic [5:0] lm; logic [5:0] ls; logic st; logic sp; obs_t e;
   } row_t;

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic obs_t exp_o(int h, int m, int s, int run, int alm, int err);
      obs_t o;
      o.h = 5'(h); o.m = 6'(m); o.s = 6'(s);
      o.run = 1'(run); o.alm = 1'(alm); o.err = 1'(err);
      return o;
   endfunction

   function automatic row_t r(int ld, int lh, int lm, int ls, int st, int sp,
                              int h, int m, int s, int run, int alm, int err);
      row_t x;
      x.ld = 1'(ld); x.lh = 5'(lh); x.lm = 6'(lm); x.ls = 6'(ls);
      x.st = 1'(st); x.sp = 1'(sp);
      x.e  = exp_o(h, m, s, run, alm, err);
      return x;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.h = hours; o.m = minutes; o.s = seconds;
      o.run = running; o.alm = alarm; o.err = load_err;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("%0d:%0d:%0d run=%b alarm=%b err=%b", o.h, o.m, o.s, o.run, o.alm, o.err);
   endfunction

   task automatic drive_row(input row_t x);
      load = x.ld; load_hours = x.lh; load_minutes = x.lm; load_seconds = x.ls;
      start = x.st; stop = x.sp;
      sb.push_back(x.e);
   endtask

   task automatic test_reset();
      obs_t act, want;
      row_t t[$];
      reset = 1'b1; load = 1'b1; load_hours = 5'd0; load_minutes = 6'd0; load_seconds = 6'd5;
      start = 1'b1; stop = 1'b0;
      sb.push_back(exp_o(0, 0, 0, 0, 0, 0));
      #1;
      act = sample(); want = sb.pop_front(); n_cmp++;
      if (act !== want) begin
         n_bad++; $display("FAIL reset_async got %s want %s", fmt(act), fmt(want));
      end
      sb.push_back(exp_o(0, 0, 0, 0, 0, 0));
      @(posedge Clk_1sec); #1;
      act = sample(); want = sb.pop_front(); n_cmp++;
      if (act !== want) begin
         n_bad++; $display("FAIL reset_held got %s want %s", fmt(act), fmt(want));
      end
      reset = 1'b0;
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL reset_after[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_basic_alarm();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,3,0,0, 0,0,3,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,3,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,2,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1,1,0,0));
      for (int k = 0; k < 5; k++) t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL basic[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

   task automatic test_alarm_ack();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,1,0,0, 0,0,1,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,1,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,1,0));
      t.push_back(r(0,0,0,0,0,1, 0,0,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,0,0));
      t.push_back(r(1,0,0,1,0,0, 0,0,1,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,1,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      t.push_back(r(1,0,0,2,0,0, 0,0,2,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,2,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1,1,0,0));
      for (int k = 0; k < 5; k++) t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL alarm_ack[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask
`endif

   task automatic test_borrow();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,1,0,0,0,0, 1,0,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 1,0,0,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,59,59,1,0,0));
      t.push_back(r(1,0,1,0,0,0, 0,1,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,1,0,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,59,1,0,0));
      t.push_back(r(1,0,0,0,0,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL borrow[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

   task automatic test_pause();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,10,0,0, 0,0,10,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,10,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,9,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,8,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,7,1,0,0));
      for (int k = 0; k < 4; k++) t.push_back(r(0,0,0,0,0,1, 0,0,7,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,7,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,6,1,0,0));
      t.push_back(r(1,0,0,0,0,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL pause[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

   task automatic test_load_err();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,5,0,0, 0,0,5,0,0,0));
      t.push_back(r(1,24,0,0,0,0, 0,0,5,0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,5,0,0,0));
      t.push_back(r(1,0,60,0,0,0, 0,0,5,0,0,1));
      t.push_back(r(1,0,0,60,0,0, 0,0,5,0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,5,0,0,0));
      t.push_back(r(1,23,59,59,0,0, 23,59,59,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 23,59,59,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 23,59,58,1,0,0));
      t.push_back(r(1,0,0,0,0,0, 0,0,0,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL load_err[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

   task automatic test_priority();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,9,0,0, 0,0,9,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,9,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,8,1,0,0));
      t.push_back(r(1,0,0,4,1,1, 0,0,4,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,4,1,0,0));
      t.push_back(r(0,0,0,0,1,1, 0,0,4,0,0,0));
      t.push_back(r(0,0,0,0,0,1, 0,0,4,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,4,1,0,0));
      t.push_back(r(1,0,0,0,0,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL priority[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask

   task automatic test_reset_abort();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,9,0,0, 0,0,9,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,9,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,8,1,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL abort_pre[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
      #2 reset = 1'b1;
      sb.push_back(exp_o(0, 0, 0, 0, 0, 0));
      #1;
      act = sample(); want = sb.pop_front(); n_cmp++;
      if (act !== want) begin
         n_bad++; $display("FAIL abort_midrun got %s want %s", fmt(act), fmt(want));
      end
      @(posedge Clk_1sec); #1;
      reset = 1'b0;
      t.delete();
      t.push_back(r(0,0,0,0,1,0, 0,0,0,0,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL abort_post[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      t.delete();
      t.push_back(r(1,0,0,1,0,0, 0,0,1,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,1,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0,0,1,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL abort_alarm_pre[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
      #2 reset = 1'b1;
      sb.push_back(exp_o(0, 0, 0, 0, 0, 0));
      #1;
      act = sample(); want = sb.pop_front(); n_cmp++;
      if (act !== want) begin
         n_bad++; $display("FAIL abort_midalarm got %s want %s", fmt(act), fmt(want));
      end
      @(posedge Clk_1sec); #1;
      reset = 1'b0;
`endif
   endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      obs_t act, want;
      row_t t[$];
      t.push_back(r(1,0,0,2,0,0, 0,0,2,0,0,0));
      t.push_back(r(0,0,0,0,1,0, 0,0,2,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,2,1,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1,1,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,2,1,1,0));
      t.push_back(r(0,0,0,0,0,1, 0,0,2,0,0,0));
      foreach (t[i]) begin
         drive_row(t[i]); @(posedge Clk_1sec); #1;
         act = sample(); want = sb.pop_front(); n_cmp++;
         if (act !== want) begin
            n_bad++; $display("FAIL auto_reload[%0d] got %s want %s", i, fmt(act), fmt(want));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      test_basic_alarm();
      test_alarm_ack();
`else
      test_auto_reload();
`endif
      test_borrow();
      test_pause();
      test_load_err();
      test_priority();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_HOLD, default 5, number of Clk_1sec cycles the alarm output SHALL remain high after expiry (legal range 1..63).
REQ-002 Clk_1sec  in  1  1 Hz clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 load  in  1  load request; samples load_hours/minutes/seconds.
REQ-005 load_hours  in  5  preset hours, legal 0..23.
REQ-006 load_minutes  in  6  preset minutes, legal 0..59.
REQ-007 load_seconds  in  6  preset seconds, legal 0..59.
REQ-008 start  in  1  begin or resume counting.
REQ-009 stop  in  1  pause counting.
REQ-010 hours  out  5  remaining hours.
REQ-011 minutes  out  6  remaining minutes.
REQ-012 seconds  out  6  remaining seconds.
REQ-013 running  out  1  high while in state RUN.
REQ-014 alarm  out  1  high while in state ALARM.
REQ-015 load_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-016 The block SHALL implement states IDLE, RUN, PAUSE, ALARM; running = (state==RUN), alarm = (state==ALARM).
REQ-017 Input priority per edge SHALL be load > stop > start.
REQ-018 A load with all three fields legal SHALL, on that edge, copy the fields to hours/minutes/seconds and to an internal reload register, and force state IDLE from any state.
REQ-019 A load with any field out of range SHALL leave time, reload register and state unchanged and pulse load_err high for exactly one cycle.
REQ-020 start in IDLE or PAUSE SHALL enter RUN on that edge only if the time is nonzero; with time 00:00:00 start SHALL be ignored.
REQ-021 stop in RUN SHALL enter PAUSE with time frozen; stop in any other state SHALL have no effect.
REQ-022 In RUN, each edge without load/stop SHALL decrement the time by one second: seconds>0 -> seconds-1; else minutes>0 -> seconds=59, minutes-1; else hours>0 -> seconds=59, minutes=59, hours-1.
REQ-023 The edge on which the time becomes 00:00:00 SHALL also move state RUN -> ALARM (no extra cycle at zero in RUN).
REQ-024 The decrement on the edge on which start is accepted SHALL NOT occur; the first decrement SHALL be on the following edge.
REQ-025 ALARM SHALL last exactly ALARM_HOLD cycles, then return to IDLE with time 00:00:00; start in ALARM SHALL be ignored; stop in ALARM SHALL return to IDLE immediately (alarm acknowledge).
REQ-026 Time outputs SHALL never leave the legal ranges of REQ-005..007; no underflow below 00:00:00.

Reset
REQ-027 While reset is high, asynchronously: state=IDLE, hours=0, minutes=0, seconds=0, reload register=0, running=0, alarm=0, load_err=0, ALARM hold counter=0.
REQ-028 Reset asserted mid-RUN or mid-ALARM SHALL abort the operation; after release the block SHALL stay IDLE until a valid load and start.

Configuration
REQ-029 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select auto-reload.
REQ-030 With COUNTDOWN_AUTO_RELOAD_EN defined: on the expiry edge of REQ-023 the block SHALL load the reload register into the time, remain in RUN, and assert alarm for that single cycle only (ALARM_HOLD ignored); a reload register of 00:00:00 SHALL instead go to IDLE.
REQ-031 Without COUNTDOWN_AUTO_RELOAD_EN: behaviour per REQ-023 and REQ-025; no reload on expiry.

Verification
REQ-032 Reset, load 00:00:03, start, 4 edges -> seconds 3,3,2,1,0; alarm high on the edge seconds hit 0, held 5 cycles, then IDLE at 00:00:00.
REQ-033 Load 01:00:00, start, 1 edge after start -> 00:59:59; load 00:01:00 -> 00:00:59 after one RUN edge.
REQ-034 Load 00:00:10, start, run 3 edges, stop for 4 edges, start -> time frozen at 00:00:07 during PAUSE, resumes 6 on the edge after start.
REQ-035 Load 24:00:00 or 00:60:00 -> load_err one-cycle pulse, time and state unchanged; start with 00:00:00 -> running stays 0.
REQ-036 Load+stop+start asserted together in RUN -> load wins, IDLE with new time; reset asserted mid-RUN between edges -> all outputs 0 immediately.
REQ-037 With COUNTDOWN_AUTO_RELOAD_EN, load 00:00:02, start -> sequence 2,1,2(alarm=1 one cycle),1,... running stays 1.
